// File: rtl/cube_layer_driver.sv
// cube_layer_driver: display back end for the 8x8x8 LED cube.
// Snapshots the 512-bit cell vector at the start of each frame, then for each
// layer shifts 64 column bits out serially, pulses the storage latch, and
// lights that layer for a fixed dwell time. FrameDone pulses after layer 7.

module cube_layer_driver #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned DWELL   = 4000
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Enable,
    input  logic [511:0] Cells,
    output logic         SerData,
    output logic         SerClk,
    output logic         Latch,
    output logic [7:0]   LayerSel,
    output logic         FrameDone
);

    localparam int unsigned DIV_W   = $clog2(CLK_DIV + 1);
    localparam int unsigned DWELL_W = $clog2(DWELL + 1);
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_LATCH,
        S_DWELL
    } state_t;

    state_t               state;
    logic [2:0]           layer;
    logic [511:0]         frame_buf;
    logic [63:0]          shift_reg;
    logic [5:0]           bit_cnt;
    logic [DIV_W-1:0]     div_cnt;
    logic [DWELL_W-1:0]   dwell_cnt;

    logic [511:0]         src;
    logic [63:0]          layer_bits;

    // Column bits of the current layer; layer 0 reads Cells directly because
    // frame_buf is only being captured in that same S_LOAD cycle.
    always_comb begin
        src        = (layer == 3'd0) ? Cells : frame_buf;
        layer_bits = '0;
        for (int unsigned z = 0; z < 8; z++) begin
            for (int unsigned x = 0; x < 8; x++) begin
                layer_bits[{z[2:0], x[2:0]}] = src[{z[2:0], layer, x[2:0]}];
            end
        end
    end

    // Scan state machine with registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= S_IDLE;
            layer     <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            dwell_cnt <= '0;
            SerData   <= 1'b0;
            SerClk    <= 1'b0;
            Latch     <= 1'b0;
            LayerSel  <= '0;
            FrameDone <= 1'b0;
        end else begin
            FrameDone <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Enable) begin
                        layer <= '0;
                        state <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    if (layer == 3'd0) begin
                        frame_buf <= Cells;
                    end
                    SerData   <= layer_bits[63];
                    shift_reg <= {layer_bits[62:0], 1'b0};
                    SerClk    <= 1'b0;
                    div_cnt   <= '0;
                    bit_cnt   <= '0;
                    state     <= S_SHIFT;
                end

                S_SHIFT: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else begin
                        div_cnt <= '0;
                        if (!SerClk) begin
                            SerClk <= 1'b1;
                        end else if (bit_cnt == 6'd63) begin
                            SerClk <= 1'b0;
                            Latch  <= 1'b1;
                            state  <= S_LATCH;
                        end else begin
                            SerClk    <= 1'b0;
                            SerData   <= shift_reg[63];
                            shift_reg <= {shift_reg[62:0], 1'b0};
                            bit_cnt   <= bit_cnt + 6'd1;
                        end
                    end
                end

                S_LATCH: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else begin
                        div_cnt   <= '0;
                        Latch     <= 1'b0;
                        LayerSel  <= 8'd1 << layer;
                        dwell_cnt <= '0;
                        state     <= S_DWELL;
                    end
                end

                S_DWELL: begin
                    if (dwell_cnt != DWELL_LAST) begin
                        dwell_cnt <= dwell_cnt + DWELL_W'(1);
                    end else begin
                        LayerSel  <= '0;
                        layer     <= layer + 3'd1;
                        FrameDone <= (layer == 3'd7);
                        state     <= Enable ? S_LOAD : S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cube_layer_driver.sv
// Testbench for cube_layer_driver (CLK_DIV=1, DWELL=4): directed vectors
// compared against hand-computed layer words, plus multi-cycle sequences.

module tb_cube_layer_driver;

    logic         Clk;
    logic         Reset;
    logic         Enable;
    logic [511:0] Cells;
    logic         SerData;
    logic         SerClk;
    logic         Latch;
    logic [7:0]   LayerSel;
    logic         FrameDone;

    cube_layer_driver #(
        .CLK_DIV(1),
        .DWELL  (4)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Enable   (Enable),
        .Cells    (Cells),
        .SerData  (SerData),
        .SerClk   (SerClk),
        .Latch    (Latch),
        .LayerSel (LayerSel),
        .FrameDone(FrameDone)
    );

    typedef struct packed {
        logic [511:0]     cells;
        logic [7:0][63:0] exp_w;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int fall_cyc;

    // Monitor state
    int          idx;
    int          rises;
    int          fd_count;
    int          fd_cyc;
    logic        prev_sc;
    logic        prev_la;
    logic [63:0] acc;
    logic [63:0] words     [32];
    int          first_rise[32];
    int          rise_cnt  [32];
    int          dwell     [32];
    logic [7:0]  lsel      [32];

    // Clock generation
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Cycle counter
    always @(posedge Clk) cyc++;

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Observe the serial/latch/layer outputs on the falling clock edge.
    always @(negedge Clk) begin
        if (Reset) begin
            idx      = 0;
            rises    = 0;
            fd_count = 0;
            fd_cyc   = 0;
            acc      = '0;
            prev_sc  = 1'b0;
            prev_la  = 1'b0;
            for (int k = 0; k < 32; k++) begin
                words[k]      = '0;
                first_rise[k] = 0;
                rise_cnt[k]   = 0;
                dwell[k]      = 0;
                lsel[k]       = '0;
            end
        end else begin
            if (SerClk && !prev_sc) begin
                if (rises == 0) first_rise[idx % 32] = cyc;
                acc = {acc[62:0], SerData};
                rises++;
            end
            if (Latch && !prev_la) begin
                words[idx % 32]    = acc;
                rise_cnt[idx % 32] = rises;
                rises = 0;
                idx++;
            end
            if (LayerSel != 8'h00 && idx > 0) begin
                lsel[(idx - 1) % 32] = LayerSel;
                dwell[(idx - 1) % 32]++;
            end
            if (FrameDone) begin
                fd_count++;
                fd_cyc = cyc;
            end
            prev_sc = SerClk;
            prev_la = Latch;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic start_run();
        Reset  = 1'b1;
        Enable = 1'b1;
        repeat (3) tick();
        Reset    = 1'b0;
        fall_cyc = cyc;
    endtask

    vec_t vecs[6];

    initial begin
        Reset  = 1'b1;
        Enable = 1'b1;
        Cells  = '0;

        for (int i = 0; i < 6; i++) begin
            vecs[i].cells = '0;
            vecs[i].exp_w = '0;
        end
        vecs[0].cells[0]   = 1'b1;  vecs[0].exp_w[0] = 64'h0000_0000_0000_0001;
        vecs[1].cells[511] = 1'b1;  vecs[1].exp_w[7] = 64'h8000_0000_0000_0000;
        vecs[2].cells[339] = 1'b1;  vecs[2].exp_w[2] = 64'h0000_0800_0000_0000;
        vecs[3].cells[56]  = 1'b1;  vecs[3].exp_w[7] = 64'h0000_0000_0000_0001;
        vecs[4].cells[455] = 1'b1;  vecs[4].exp_w[0] = 64'h8000_0000_0000_0000;
        vecs[5].cells = {8{64'h0000_FF00_0000_0000}};
        vecs[5].exp_w[5] = 64'hFFFF_FFFF_FFFF_FFFF;

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            int n;
            Cells = vecs[i].cells;
            start_run();
            if (i == 0) begin
                chk("reset_outputs", {59'd0, SerData, SerClk, Latch, (LayerSel != 8'h00), FrameDone}, 64'd0);
                chk("reset_layersel", {56'd0, LayerSel}, 64'd0);
            end
            n = 0;
            while (fd_count < 1 && n < 1300) begin tick(); n++; end
            chk($sformatf("vec%0d_framedone_seen", i), 64'(n < 1300), 64'd1);
            repeat (3) tick();
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("vec%0d_layer%0d_word", i, k), words[k], vecs[i].exp_w[k]);
            end
            if (i == 0) begin
                chk("first_rise_after_reset", 64'(first_rise[0] - fall_cyc), 64'd3);
                chk("layer0_rises", 64'(rise_cnt[0]), 64'd64);
                chk("layer0_sel", {56'd0, lsel[0]}, 64'h01);
                chk("layer0_dwell", 64'(dwell[0]), 64'd4);
                chk("layer_period", 64'(first_rise[1] - first_rise[0]), 64'd134);
            end
            if (i == 1) begin
                chk("layer7_sel", {56'd0, lsel[7]}, 64'h80);
                chk("layer7_dwell", 64'(dwell[7]), 64'd4);
                chk("framedone_time", 64'(fd_cyc - first_rise[0]), 64'd1070);
                chk("framedone_width", 64'(fd_count), 64'd1);
                n = 0;
                while (LayerSel == 8'h00 && n < 300) begin tick(); n++; end
                chk("wrap_next_layer_sel", {56'd0, LayerSel}, 64'h01);
            end
        end

        // Frame atomicity: Cells change during layer 3
        begin
            int n;
            Cells = '0;
            start_run();
            n = 0;
            while (idx < 4 && n < 700) begin tick(); n++; end
            chk("atomic_reach_layer3", 64'(n < 700), 64'd1);
            Cells = '1;
            n = 0;
            while (fd_count < 2 && n < 2500) begin tick(); n++; end
            chk("atomic_two_frames", 64'(n < 2500), 64'd1);
            for (int k = 0; k < 8; k++)
                chk($sformatf("atomic_f0_layer%0d", k), words[k], 64'd0);
            for (int k = 8; k < 16; k++)
                chk($sformatf("atomic_f1_layer%0d", k - 8), words[k], 64'hFFFF_FFFF_FFFF_FFFF);
        end

        // Enable dropped during layer 2 shift
        begin
            int n;
            Cells = '0;
            Cells[0] = 1'b1;
            start_run();
            n = 0;
            while (!(idx == 2 && rises >= 10) && n < 600) begin tick(); n++; end
            chk("en_reach_layer2", 64'(n < 600), 64'd1);
            Enable = 1'b0;
            repeat (200) tick();
            chk("en_latches", 64'(idx), 64'd3);
            chk("en_layer2_sel", {56'd0, lsel[2]}, 64'h04);
            chk("en_layer2_dwell", 64'(dwell[2]), 64'd4);
            chk("en_no_framedone", 64'(fd_count), 64'd0);
            chk("en_idle_outputs", {60'd0, SerClk, Latch, (LayerSel != 8'h00), FrameDone}, 64'd0);
            Enable = 1'b1;
            n = 0;
            while (!(idx >= 4 && LayerSel != 8'h00) && n < 300) begin tick(); n++; end
            chk("en_restart_sel", {56'd0, LayerSel}, 64'h01);
            chk("en_restart_word", words[3], 64'h0000_0000_0000_0001);
        end

        // Reset mid-shift and mid-dwell
        begin
            int n;
            start_run();
            n = 0;
            while (rises < 20 && n < 200) begin tick(); n++; end
            chk("rst_shift_reached", 64'(n < 200), 64'd1);
            Reset = 1'b1;
            tick();
            chk("rst_shift_outputs", {59'd0, SerData, SerClk, Latch, (LayerSel != 8'h00), FrameDone}, 64'd0);
            Reset    = 1'b0;
            fall_cyc = cyc;
            n = 0;
            while (!(idx == 2 && LayerSel != 8'h00) && n < 400) begin tick(); n++; end
            chk("rst_dwell_reached", {56'd0, LayerSel}, 64'h02);
            Reset = 1'b1;
            tick();
            chk("rst_dwell_outputs", {60'd0, SerClk, Latch, (LayerSel != 8'h00), FrameDone}, 64'd0);
            Reset    = 1'b0;
            fall_cyc = cyc;
            n = 0;
            while (LayerSel == 8'h00 && n < 300) begin tick(); n++; end
            chk("rst_restart_first_rise", 64'(first_rise[0] - fall_cyc), 64'd3);
            chk("rst_restart_sel", {56'd0, LayerSel}, 64'h01);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
